// File: rtl/merge5_leaf.sv
// merge5_leaf: two-into-one packet-granular merge with a registered output FIFO.
// Each buffered entry is {source, flit}; bit W-1 of a flit marks the packet tail.
module merge5_leaf #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 2
) (
  input  logic         CLK,
  input  logic         _RESET,
  input  logic [W-1:0] In0_data,
  input  logic         In0_valid,
  output logic         In0_ready,
  input  logic [W-1:0] In1_data,
  input  logic         In1_valid,
  output logic         In1_ready,
  output logic [W-1:0] Out_data,
  output logic         S,
  output logic         Out_valid,
  input  logic         Out_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          lock;
  logic          owner;
  logic          last;

  logic          grant_vld;
  logic          grant_idx;
  logic          space;
  logic          push;
  logic          pop;
  logic [W-1:0]  push_data;

  // Packet-level arbitration: a locked owner keeps the grant, otherwise round robin.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    if (lock) begin
      grant_idx = owner;
      grant_vld = owner ? In1_valid : In0_valid;
    end else if (In0_valid && !In1_valid) begin
      grant_vld = 1'b1;
      grant_idx = 1'b0;
    end else if (In1_valid && !In0_valid) begin
      grant_vld = 1'b1;
      grant_idx = 1'b1;
    end else if (In0_valid && In1_valid) begin
      grant_vld = 1'b1;
      grant_idx = ~last;
    end
  end

  // Handshake: a full buffer still accepts when its head leaves in the same cycle.
  always_comb begin
    Out_valid = (count != '0);
    pop       = Out_valid && Out_ready;
    space     = (count < CW'(DEPTH)) || pop;
    In0_ready = space && grant_vld && !grant_idx;
    In1_ready = space && grant_vld && grant_idx;
    push      = In0_ready || In1_ready;
    push_data = grant_idx ? In1_data : In0_data;
    Out_data  = mem[rd_ptr][W-1:0];
    S         = mem[rd_ptr][W];
  end

  // Buffer storage, pointers, occupancy and arbitration state.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      lock   <= 1'b0;
      owner  <= 1'b0;
      last   <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {grant_idx, push_data};
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
        if (push_data[W-1]) begin
          lock <= 1'b0;
          last <= grant_idx;
        end else begin
          lock  <= 1'b1;
          owner <= grant_idx;
        end
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_merge5_leaf.sv
// Self-checking bench for merge5_leaf: directed scenarios plus randomized traffic
// compared against a queue-based packet-merge reference model.
module tb_merge5_leaf;

  localparam int unsigned W     = 9;
  localparam int unsigned DEPTH = 2;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in0_data;
  logic         in0_valid;
  logic         in0_ready;
  logic [W-1:0] in1_data;
  logic         in1_valid;
  logic         in1_ready;
  logic [W-1:0] out_data;
  logic         s;
  logic         out_valid;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  // Reference model state: expected buffer contents and arbitration state.
  logic [W:0]   exp_q[$];
  logic [W-1:0] src0_q[$];
  logic [W-1:0] src1_q[$];
  bit           m_lock;
  bit           m_owner;
  bit           m_last;

  merge5_leaf #(.W(W), .DEPTH(DEPTH)) dut (
    .CLK       (clk),
    ._RESET    (rst_n),
    .In0_data  (in0_data),
    .In0_valid (in0_valid),
    .In0_ready (in0_ready),
    .In1_data  (in1_data),
    .In1_valid (in1_valid),
    .In1_ready (in1_ready),
    .Out_data  (out_data),
    .S         (s),
    .Out_valid (out_valid),
    .Out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_lock  = 1'b0;
    m_owner = 1'b0;
    m_last  = 1'b1;
  endtask

  task automatic model_accept(input bit src, input logic [W-1:0] d);
    exp_q.push_back({src, d});
    if (d[W-1]) begin
      m_lock = 1'b0;
      m_last = src;
    end else begin
      m_lock  = 1'b1;
      m_owner = src;
    end
  endtask

  // One clock cycle: called at a falling edge, drives inputs, checks, advances.
  task automatic cycle(input bit en0, input bit en1, input bit ordy);
    bit v0, v1, gv, gi, pop_e, space_e, r0, r1;
    int n;
    v0 = en0 && (src0_q.size() > 0);
    v1 = en1 && (src1_q.size() > 0);
    in0_valid = v0;
    in1_valid = v1;
    in0_data  = v0 ? src0_q[0] : W'($urandom);
    in1_data  = v1 ? src1_q[0] : W'($urandom);
    out_ready = ordy;
    #1;
    n = exp_q.size();
    gv = 1'b0;
    gi = 1'b0;
    if (m_lock) begin
      gi = m_owner;
      gv = m_owner ? v1 : v0;
    end else if (v0 && v1) begin
      gv = 1'b1;
      gi = ~m_last;
    end else if (v0 || v1) begin
      gv = 1'b1;
      gi = v1;
    end
    pop_e   = (n > 0) && ordy;
    space_e = (n < DEPTH) || pop_e;
    r0 = space_e && gv && !gi;
    r1 = space_e && gv && gi;
    check("in0_ready", 32'(in0_ready), 32'(r0));
    check("in1_ready", 32'(in1_ready), 32'(r1));
    check("out_valid", 32'(out_valid), 32'(n > 0));
    if (n > 0) check("head", 32'({s, out_data}), 32'(exp_q[0]));
    if (pop_e) void'(exp_q.pop_front());
    if (r0) model_accept(1'b0, src0_q.pop_front());
    if (r1) model_accept(1'b1, src1_q.pop_front());
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse launched between edges; called at a falling edge.
  task automatic reset_pulse();
    #2;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_in0_ready", 32'(in0_ready), 32'd0);
    check("rst_in1_ready", 32'(in1_ready), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic gen_pkt(input bit src);
    int len;
    logic [W-1:0] d;
    len = int'($urandom_range(1, 4));
    for (int i = 0; i < len; i++) begin
      d = {(i == len - 1) ? 1'b1 : 1'b0, 8'($urandom)};
      if (src) src1_q.push_back(d);
      else     src0_q.push_back(d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    in0_data  = '0;
    in1_data  = '0;
    out_ready = 1'b0;
    model_reset();
    #1;
    check("init_out_valid", 32'(out_valid), 32'd0);
    check("init_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream, then first tie goes to In0.
    src0_q = '{9'h001, 9'h002, 9'h003};
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    reset_pulse();
    src0_q = '{9'h1AA};
    src1_q = '{9'h155};
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1);

    // Packet lock holds off In1 until In0's tail.
    src0_q = '{9'h011, 9'h022, 9'h133};
    src1_q = '{9'h1FF};
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b1);

    // Round robin on single-flit packets.
    for (int i = 0; i < 8; i++) begin
      src0_q.push_back(W'(9'h100 + i));
      src1_q.push_back(W'(9'h180 + i));
    end
    for (int i = 0; i < 18; i++) cycle(1'b1, 1'b1, 1'b1);

    // Back-pressure to full, then pass-through with no bubble.
    src0_q = '{9'h101, 9'h102, 9'h103, 9'h104, 9'h105};
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    check("full_count", 32'(exp_q.size()), 32'(DEPTH));
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1);

    // Owner stalls mid-packet; In1 stays blocked.
    src0_q = '{9'h005, 9'h106};
    src1_q = '{9'h1A5};
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1);

    // Reset while In1 holds the lock; In0 is granted right after release.
    src1_q = '{9'h044, 9'h145};
    cycle(1'b0, 1'b1, 1'b1);
    reset_pulse();
    src0_q = '{9'h1AB};
    src1_q.delete();
    cycle(1'b1, 1'b1, 1'b1);
    check("post_rst_head", 32'({s, out_data}), 32'({1'b0, 9'h1AB}));
    drain();

    // Randomized traffic with random valid gaps and back-pressure.
    for (int i = 0; i < 3000; i++) begin
      if (src0_q.size() < 3) gen_pkt(1'b0);
      if (src1_q.size() < 3) gen_pkt(1'b1);
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) != 0));
    end
    drain();
    check("final_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
